bmp_to_sdram_writer: RTL and testbench

//  Upstream loader for the LCD display path. Takes a stream of raw BMP pixel bytes (B,G,R order;

---
 rtl/bmp_to_sdram_writer_if.sv | 23 ++
 rtl/bmp_to_sdram_writer.sv | 244 ++++++++++++++++++++++++
 tb/tb_bmp_to_sdram_writer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_to_sdram_writer_if.sv
// Pixel byte stream plus ahb_master burst-write handshake for bmp_to_sdram_writer.
// The writer (DUT) uses the master modport; the byte source / ahb_master side uses slave.
interface bmp_to_sdram_writer_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        dma_start_xfer;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [7:0]  dma_burst_count;
  logic        ahm_wdata_pop;
  logic        ahm_xfer_done;

  modport master (
    input  s_valid, s_data, ahm_wdata_pop, ahm_xfer_done,
    output s_ready, dma_start_xfer, dma_addr, dma_wdata, dma_burst_count
  );

  modport slave (
    output s_valid, s_data, ahm_wdata_pop, ahm_xfer_done,
    input  s_ready, dma_start_xfer, dma_addr, dma_wdata, dma_burst_count
  );
endinterface

// File: rtl/bmp_to_sdram_writer.sv
// BMP (B,G,R bytes) to RGB565 packer with a 2-half ping-pong word buffer, draining each
// full half to DDR as one fixed-length ahb_master write burst, bottom line first.
module bmp_to_sdram_writer #(
  parameter int unsigned H_PIXELS    = 1024,
  parameter int unsigned V_LINES     = 768,
  parameter int unsigned BURST_WORDS = 256,
  parameter logic [3:0]  ADDR_HI     = 4'h6
) (
  input  logic                  clk_ahb,
  input  logic                  rst_ahb,
  input  logic                  frame_start,
  input  logic [3:0]            fig_idx,
  input  logic                  region,
  bmp_to_sdram_writer_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  xfer_err
);

  localparam int unsigned TOTAL_BURSTS = V_LINES * H_PIXELS / (2 * BURST_WORDS);
  localparam int unsigned PTR_W        = $clog2(BURST_WORDS);
  localparam int unsigned CNT_W        = $clog2(TOTAL_BURSTS + 1);

  localparam logic [PTR_W:0]   POPS_FULL  = (PTR_W + 1)'(BURST_WORDS);
  localparam logic [PTR_W-1:0] PTR_LAST   = '1;
  localparam logic [CNT_W-1:0] HALVES_ALL = CNT_W'(TOTAL_BURSTS);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(TOTAL_BURSTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REQ, ST_XFER} state_t;

  state_t state, state_n;

  logic [31:0]      mem [0:2*BURST_WORDS-1];
  logic             mem_we;
  logic [31:0]      mem_wdata;

  logic [1:0]       byte_phase, byte_phase_n;
  logic             pix_sel, pix_sel_n;
  logic [4:0]       blue, blue_n;
  logic [5:0]       green, green_n;
  logic [15:0]      pix0, pix0_n;
  logic [15:0]      pixel;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [PTR_W:0]   pop_cnt, pop_cnt_n;
  logic [PTR_W:0]   pops_total;
  logic             fill_half, fill_half_n;
  logic             drain_half, drain_half_n;
  logic [1:0]       full, full_n;
  logic [CNT_W-1:0] fill_cnt, fill_cnt_n;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_n;

  logic             busy_q, busy_n;
  logic             err_q, err_n;
  logic             done_q, done_n;
  logic             s_ready_q, s_ready_n;
  logic [3:0]       fig_q, fig_n;
  logic             region_q, region_n;

  logic             accept;
  logic             dma_active;
  logic [9:0]       line;
  logic             unused_lsbs;

  assign accept      = bus.s_valid && s_ready_q;
  assign pixel       = {bus.s_data[7:3], green, blue};
  assign mem_wdata   = {pixel, pix0};
  assign pops_total  = pop_cnt + {{PTR_W{1'b0}}, bus.ahm_wdata_pop};
  assign unused_lsbs = ^bus.s_data[1:0];

  // BMP stores rows bottom-up: burst pair 0 lands on the last display line.
  assign line = 10'(V_LINES - 1 - (32'(burst_cnt) >> 1));

  assign dma_active          = (state == ST_REQ) || (state == ST_XFER);
  assign bus.s_ready         = s_ready_q;
  assign bus.dma_start_xfer  = (state == ST_REQ);
  assign bus.dma_addr        = dma_active ?
                               {ADDR_HI, 2'b00, region_q, fig_q, line, burst_cnt[0], 10'h000} : '0;
  assign bus.dma_wdata       = dma_active ? mem[{drain_half, rd_ptr}] : '0;
  assign bus.dma_burst_count = 8'(BURST_WORDS - 1);

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign xfer_err   = err_q;

  always_ff @(posedge clk_ahb or posedge rst_ahb) begin
    if (rst_ahb) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n      = state;
    busy_n       = busy_q;
    err_n        = err_q;
    done_n       = 1'b0;
    fig_n        = fig_q;
    region_n     = region_q;
    byte_phase_n = byte_phase;
    pix_sel_n    = pix_sel;
    blue_n       = blue;
    green_n      = green;
    pix0_n       = pix0;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    pop_cnt_n    = pop_cnt;
    fill_half_n  = fill_half;
    drain_half_n = drain_half;
    full_n       = full;
    fill_cnt_n   = fill_cnt;
    burst_cnt_n  = burst_cnt;
    mem_we       = 1'b0;

    // Fill side: only ever touches full[fill_half], so it can coexist with a drain clear.
    if (accept) begin
      case (byte_phase)
        2'd0: begin
          blue_n       = bus.s_data[7:3];
          byte_phase_n = 2'd1;
        end
        2'd1: begin
          green_n      = bus.s_data[7:2];
          byte_phase_n = 2'd2;
        end
        default: begin
          byte_phase_n = 2'd0;
          pix_sel_n    = ~pix_sel;
          if (!pix_sel) begin
            pix0_n = pixel;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            if (wr_ptr == PTR_LAST) begin
              full_n[fill_half] = 1'b1;
              fill_half_n       = ~fill_half;
              fill_cnt_n        = fill_cnt + 1'b1;
            end
          end
        end
      endcase
    end

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_n      = ST_WAIT;
          busy_n       = 1'b1;
          err_n        = 1'b0;
          fig_n        = fig_idx;
          region_n     = region;
          byte_phase_n = '0;
          pix_sel_n    = 1'b0;
          wr_ptr_n     = '0;
          rd_ptr_n     = '0;
          pop_cnt_n    = '0;
          fill_half_n  = 1'b0;
          drain_half_n = 1'b0;
          full_n       = '0;
          fill_cnt_n   = '0;
          burst_cnt_n  = '0;
        end
      end
      ST_WAIT: begin
        if (full[drain_half]) state_n = ST_REQ;
      end
      ST_REQ: begin
        state_n = ST_XFER;
      end
      default: begin
        if (bus.ahm_wdata_pop) begin
          rd_ptr_n  = rd_ptr + 1'b1;
          pop_cnt_n = pop_cnt + 1'b1;
        end
        if (bus.ahm_xfer_done) begin
          if (pops_total != POPS_FULL) err_n = 1'b1;
          full_n[drain_half] = 1'b0;
          drain_half_n       = ~drain_half;
          rd_ptr_n           = '0;
          pop_cnt_n          = '0;
          burst_cnt_n        = burst_cnt + 1'b1;
          if (burst_cnt == BURST_LAST) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
    endcase

    // Registered ready is derived from next-cycle state so a just-filled half stalls at once.
    s_ready_n = busy_n && !full_n[fill_half_n] && (fill_cnt_n != HALVES_ALL);
  end

  always_ff @(posedge clk_ahb or posedge rst_ahb) begin
    if (rst_ahb) begin
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      fig_q      <= '0;
      region_q   <= 1'b0;
      byte_phase <= '0;
      pix_sel    <= 1'b0;
      blue       <= '0;
      green      <= '0;
      pix0       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pop_cnt    <= '0;
      fill_half  <= 1'b0;
      drain_half <= 1'b0;
      full       <= '0;
      fill_cnt   <= '0;
      burst_cnt  <= '0;
    end else begin
      busy_q     <= busy_n;
      err_q      <= err_n;
      done_q     <= done_n;
      s_ready_q  <= s_ready_n;
      fig_q      <= fig_n;
      region_q   <= region_n;
      byte_phase <= byte_phase_n;
      pix_sel    <= pix_sel_n;
      blue       <= blue_n;
      green      <= green_n;
      pix0       <= pix0_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      pop_cnt    <= pop_cnt_n;
      fill_half  <= fill_half_n;
      drain_half <= drain_half_n;
      full       <= full_n;
      fill_cnt   <= fill_cnt_n;
      burst_cnt  <= burst_cnt_n;
    end
  end

  always_ff @(posedge clk_ahb) begin
    if (mem_we) mem[{fill_half, wr_ptr}] <= mem_wdata;
  end

endmodule

// File: tb/tb_bmp_to_sdram_writer.sv
// Randomized directed bench for bmp_to_sdram_writer on a reduced 2-line frame; an
// arithmetic pixel/address model supplies every expected value.
module tb_bmp_to_sdram_writer;
  localparam int TB_LINES = 2;
  localparam int NBURST   = TB_LINES * 2;
  localparam int NWORDS   = NBURST * 256;
  localparam int NBYTES   = NWORDS * 6;

  logic       clk = 1'b0;
  logic       rst_ahb;
  logic       frame_start;
  logic [3:0] fig_idx;
  logic       region;
  logic       busy, frame_done, xfer_err;

  bmp_to_sdram_writer_if bus();

  bmp_to_sdram_writer #(.V_LINES(TB_LINES)) dut (
    .clk_ahb     (clk),
    .rst_ahb     (rst_ahb),
    .frame_start (frame_start),
    .fig_idx     (fig_idx),
    .region      (region),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .xfer_err    (xfer_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  src[$];
  logic [31:0] exp_words[$];
  int          src_idx, src_pct;
  bit          src_on, sk_active, pop_en, done_same;
  int          sk_pops, burst_idx, short_burst, pop_pct;
  int          fd_cnt, req_cnt, ready_hi;
  logic [3:0]  exp_fig;
  logic        exp_region;
  logic [31:0] req_log[3];
  logic [31:0] first_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [15:0] rgb565(input int b, input int g, input int r);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  function automatic logic [31:0] exp_addr(input int b);
    int ln;
    ln = TB_LINES - 1 - b / 2;
    return 32'h6000_0000 + 32'(exp_region) * 32'h0200_0000 + 32'(exp_fig) * 32'h0020_0000
         + 32'(ln) * 32'h800 + 32'(b % 2) * 32'h400;
  endfunction

  task automatic build_frame(input int kind);
    int b, g, r;
    logic [15:0] p0;
    p0 = '0;
    src.delete();
    exp_words.delete();
    for (int i = 0; i < NWORDS * 2; i++) begin
      b = int'($urandom_range(255));
      g = int'($urandom_range(255));
      r = int'($urandom_range(255));
      if (kind == 1 && i < 1024) begin b = 0; g = 0; r = 255; end
      if (kind == 2 && i == 0) begin b = 'hF8; g = 0; r = 0; end
      if (kind == 2 && i == 1) begin b = 0; g = 'hFC; r = 0; end
      src.push_back(8'(b));
      src.push_back(8'(g));
      src.push_back(8'(r));
      if (i % 2 == 0) p0 = rgb565(b, g, r);
      else exp_words.push_back({rgb565(b, g, r), p0});
    end
    for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
  endtask

  task automatic end_burst();
    bus.ahm_xfer_done = 1'b1;
    chk("addr_hold", bus.dma_addr, exp_addr(burst_idx));
    sk_active = 1'b0;
    burst_idx++;
  endtask

  // One clock: sample at the falling edge, then drive the next inputs.
  task automatic tick();
    int lim;
    @(negedge clk);
    if (frame_done) fd_cnt++;
    if (bus.s_ready) ready_hi++;
    bus.s_valid = 1'b0;
    if (src_on && src_idx < src.size() && $urandom_range(99) < src_pct) begin
      bus.s_valid = 1'b1;
      bus.s_data  = src[src_idx];
      if (bus.s_ready) src_idx++;
    end
    bus.ahm_wdata_pop = 1'b0;
    bus.ahm_xfer_done = 1'b0;
    if (bus.dma_start_xfer) begin
      req_cnt++;
      chk("req_addr", bus.dma_addr, exp_addr(burst_idx));
      if (burst_idx < 3) req_log[burst_idx] = bus.dma_addr;
      sk_active = 1'b1;
      sk_pops   = 0;
    end else if (sk_active && pop_en) begin
      lim = (burst_idx == short_burst) ? 200 : 256;
      if (sk_pops < lim && $urandom_range(99) < pop_pct) begin
        bus.ahm_wdata_pop = 1'b1;
        chk("wdata", bus.dma_wdata, exp_words[burst_idx * 256 + sk_pops]);
        if (burst_idx == 0 && sk_pops == 0) first_word = bus.dma_wdata;
        sk_pops++;
        if (sk_pops == lim && done_same) end_burst();
      end else if (sk_pops == lim) begin
        end_burst();
      end
    end
  endtask

  task automatic start_frame(input int kind, input logic [3:0] f, input logic r);
    build_frame(kind);
    src_idx = 0; burst_idx = 0; sk_active = 1'b0; sk_pops = 0;
    fd_cnt = 0; req_cnt = 0;
    exp_fig = f; exp_region = r;
    fig_idx = f; region = r;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    fig_idx = 4'($urandom);
    region  = 1'($urandom);
    chk("busy_start", 32'(busy), 1);
    chk("err_clear", 32'(xfer_err), 0);
  endtask

  task automatic finish_frame();
    int budget;
    budget = 30000;
    while (burst_idx < NBURST && budget > 0) begin
      tick();
      budget--;
    end
    repeat (4) tick();
    chk("frame_budget", 32'(budget > 0), 1);
    chk("bursts", 32'(burst_idx), NBURST);
    chk("req_cnt", 32'(req_cnt), NBURST);
    chk("frame_done_cnt", 32'(fd_cnt), 1);
    chk("busy_end", 32'(busy), 0);
    chk("bytes_taken", 32'(src_idx), NBYTES);
    chk("wdata_idle", bus.dma_wdata, 0);
  endtask

  initial begin
    int b, k;
    rst_ahb = 1'b1; frame_start = 1'b0; fig_idx = '0; region = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.ahm_wdata_pop = 1'b0; bus.ahm_xfer_done = 1'b0;
    src_on = 1'b1; src_pct = 100; pop_en = 1'b1; pop_pct = 100;
    done_same = 1'b0; short_burst = -1; first_word = '0;
    src_idx = 0; burst_idx = 0; sk_active = 1'b0; sk_pops = 0;
    fd_cnt = 0; req_cnt = 0; ready_hi = 0; exp_fig = '0; exp_region = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_start", 32'(bus.dma_start_xfer), 0);
    chk("rst_addr", bus.dma_addr, 0);
    chk("rst_wdata", bus.dma_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(xfer_err), 0);
    chk("burst_count", 32'(bus.dma_burst_count), 32'hff);
    rst_ahb = 1'b0;
    tick();
    chk("idle_ready", 32'(bus.s_ready), 0);

    // Frame 1: red bottom row, gappy source and sink; frame_start while busy is ignored.
    src_pct = 85; pop_pct = 70;
    start_frame(1, 4'h3, 1'b0);
    repeat (5) tick();
    fig_idx = 4'h5; region = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    finish_frame();
    chk("red_word", first_word, 32'hF800F800);
    chk("f1_addr0", req_log[0], 32'h60600800);
    chk("f1_err", 32'(xfer_err), 0);

    // Frame 2: specific first pair and address sequence at full rate.
    src_pct = 100; pop_pct = 100;
    start_frame(2, 4'h3, 1'b0);
    finish_frame();
    chk("pair_word", first_word, 32'h07E0001F);
    chk("f2_addr0", req_log[0], 32'h60600800);
    chk("f2_addr1", req_log[1], 32'h60600C00);
    chk("f2_addr2", req_log[2], 32'h60600000);

    // Frame 3: sink holds off; both halves fill, then one drain reopens the source.
    pop_en = 1'b0;
    start_frame(0, 4'h9, 1'b1);
    repeat (4000) tick();
    chk("hold_bytes", 32'(src_idx), 3072);
    ready_hi = 0;
    repeat (50) tick();
    chk("hold_ready", 32'(ready_hi), 0);
    chk("hold_req", 32'(req_cnt), 1);
    pop_en = 1'b1;
    b = 2000;
    while (burst_idx == 0 && b > 0) begin tick(); b--; end
    chk("hold_drain", 32'(b > 0), 1);
    k = 0;
    while (!bus.s_ready && k < 5) begin tick(); k++; end
    chk("ready_recover", 32'(k >= 1 && k <= 2), 1);
    finish_frame();

    // Frame 4: second burst cut short at 200 pops.
    short_burst = 1; pop_pct = 80;
    start_frame(0, 4'hA, 1'b1);
    finish_frame();
    chk("short_err", 32'(xfer_err), 1);
    short_burst = -1;

    // Frame 5: pop every cycle, done together with the last pop.
    pop_pct = 100; done_same = 1'b1;
    start_frame(0, 4'h6, 1'b0);
    finish_frame();
    chk("same_cycle_err", 32'(xfer_err), 0);
    done_same = 1'b0;

    // Frame 6: reset while a burst is in flight.
    pop_pct = 60;
    start_frame(0, 4'h2, 1'b0);
    b = 20000;
    while (!(sk_active && sk_pops >= 10) && b > 0) begin tick(); b--; end
    chk("reach_xfer", 32'(b > 0), 1);
    rst_ahb = 1'b1;
    bus.ahm_wdata_pop = 1'b0; bus.ahm_xfer_done = 1'b0; bus.s_valid = 1'b0;
    #1;
    chk("abort_s_ready", 32'(bus.s_ready), 0);
    chk("abort_start", 32'(bus.dma_start_xfer), 0);
    chk("abort_addr", bus.dma_addr, 0);
    chk("abort_wdata", bus.dma_wdata, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(frame_done), 0);
    chk("abort_err", 32'(xfer_err), 0);
    sk_active = 1'b0;
    tick();
    rst_ahb = 1'b0;
    req_cnt = 0; ready_hi = 0;
    repeat (300) tick();
    chk("abort_no_req", 32'(req_cnt), 0);
    chk("abort_no_ready", 32'(ready_hi), 0);
    chk("abort_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
